// File: rtl/wfunc_apb_loader.sv
// -----------------------------------------------------------------------------
// wfunc_apb_loader
//
// APB initiator that programs a window-function block from an AXIS coefficient
// stream. A load sequence is:
//   1. soft-reset the target FSM (toggle bit 0 of the control register),
//   2. write FFT_SIZE window samples to byte addresses 0 .. (FFT_SIZE-1)*4,
//   3. write the one-packet mode register,
//   4. (optional) read the table back and compare XOR sums,
//   5. arm the target (toggle bit 8 of the control register).
//
// The target detects commands by toggles, so the loader keeps a shadow copy
// of the last value it wrote to the control register.
//
// Optional feature macro: WFUNC_LOADER_VERIFY_EN
//   defined   : VERIFY state reads back every table word and flags err_verify
//               when the XOR of written words differs from the XOR of read words.
//   undefined : MODE goes straight to ARM, err_verify is tied 0, prdata unused.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           pulse, starts a sequence when not busy
//   one_pack        value for bit 0 of the mode register (latched at start)
//   coef_t*         AXIS coefficient slave (tdata[31:16] imag, [15:0] real)
//   psel, penable,
//   pwrite, paddr,
//   pwdata, prdata  APB initiator (no pready: 1 SETUP + 1 ACCESS cycle)
//   busy            sequence in progress
//   done            one-cycle pulse at the end of a sequence
//   err_len         sticky stream-length error, cleared by the next start
//   err_verify      sticky readback mismatch, cleared by the next start
// -----------------------------------------------------------------------------
module wfunc_apb_loader #(
    parameter int FFT_SIZE = 8192,
    parameter int APB_AW   = $clog2(FFT_SIZE - 1) + 2 + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              one_pack,
    input  logic              coef_tvalid,
    output logic              coef_tready,
    input  logic              coef_tlast,
    input  logic [31:0]       coef_tdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_verify
);

    localparam int                CW        = $clog2(FFT_SIZE);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(FFT_SIZE - 1);
    localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE * 4);
    localparam logic [APB_AW-1:0] MODE_ADDR = APB_AW'((FFT_SIZE + 1) * 4);
    localparam logic [31:0]       CMD_RESET = 32'h0000_0001;
    localparam logic [31:0]       CMD_ARM   = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_LOAD_REQ  = 3'd2,
        ST_LOAD_XFER = 3'd3,
        ST_MODE      = 3'd4,
        ST_VERIFY    = 3'd5,
        ST_ARM       = 3'd6
    } state_t;

    // phase_r: 0 = APB SETUP cycle, 1 = APB ACCESS cycle of the current transfer
    state_t         state_r, state_nxt;
    logic           phase_r, phase_nxt;
    logic [CW-1:0]  cnt_r, cnt_nxt;
    logic [31:0]    data_r, data_nxt;
    logic [31:0]    shadow_r, shadow_nxt;
    logic           one_pack_r, one_pack_nxt;
    logic           len_bad_r, len_bad_nxt;
    logic           err_len_r, err_len_nxt;
    logic           done_r, done_nxt;

    // Output decode of the next state, registered so every port is a flop
    logic              psel_s, penable_s, pwrite_s, tready_s, busy_s;
    logic [APB_AW-1:0] paddr_s;
    logic [31:0]       pwdata_s;
    logic              psel_r, penable_r, pwrite_r, tready_r, busy_r;
    logic [APB_AW-1:0] paddr_r;
    logic [31:0]       pwdata_r;

`ifdef WFUNC_LOADER_VERIFY_EN
    logic [31:0] wsum_r, wsum_nxt;
    logic [31:0] rsum_r, rsum_nxt;
    logic        err_verify_r, err_verify_nxt;
`else
    logic unused_prdata_s;
    assign unused_prdata_s = ^prdata;
`endif

    // A beat is mis-framed when tlast disagrees with its position in the table
    function automatic logic len_mismatch(input logic last, input logic [CW-1:0] cnt);
        if (last) begin
            len_mismatch = (cnt != CNT_LAST);
        end else begin
            len_mismatch = (cnt == CNT_LAST);
        end
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            phase_r <= phase_nxt;
        end
    end

    // Next-state and datapath-next logic
    always_comb begin
        state_nxt    = state_r;
        phase_nxt    = phase_r;
        cnt_nxt      = cnt_r;
        data_nxt     = data_r;
        shadow_nxt   = shadow_r;
        one_pack_nxt = one_pack_r;
        len_bad_nxt  = len_bad_r;
        err_len_nxt  = err_len_r;
        done_nxt     = 1'b0;
`ifdef WFUNC_LOADER_VERIFY_EN
        wsum_nxt       = wsum_r;
        rsum_nxt       = rsum_r;
        err_verify_nxt = err_verify_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_RST;
                    phase_nxt    = 1'b0;
                    cnt_nxt      = {CW{1'b0}};
                    one_pack_nxt = one_pack;
                    len_bad_nxt  = 1'b0;
                    err_len_nxt  = 1'b0;
`ifdef WFUNC_LOADER_VERIFY_EN
                    wsum_nxt       = 32'h0;
                    rsum_nxt       = 32'h0;
                    err_verify_nxt = 1'b0;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RST: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else begin
                    shadow_nxt = shadow_r ^ CMD_RESET;
                    phase_nxt  = 1'b0;
                    state_nxt  = ST_LOAD_REQ;
                end
            end
            ST_LOAD_REQ: begin
                if (coef_tvalid && tready_r) begin
                    data_nxt    = coef_tdata;
                    len_bad_nxt = len_mismatch(coef_tlast, cnt_r);
                    phase_nxt   = 1'b0;
                    state_nxt   = ST_LOAD_XFER;
                end else begin
                    state_nxt = ST_LOAD_REQ;
                end
            end
            ST_LOAD_XFER: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
`ifdef WFUNC_LOADER_VERIFY_EN
                    wsum_nxt = wsum_r ^ data_r;
`endif
                    // A mis-framed beat is still written, then the sequence aborts
                    if (len_bad_r) begin
                        err_len_nxt = 1'b1;
                        done_nxt    = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt = ST_MODE;
                    end else begin
                        cnt_nxt   = cnt_r + CW'(1);
                        state_nxt = ST_LOAD_REQ;
                    end
                end
            end
            ST_MODE: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
`ifdef WFUNC_LOADER_VERIFY_EN
                    cnt_nxt   = {CW{1'b0}};
                    state_nxt = ST_VERIFY;
`else
                    state_nxt = ST_ARM;
`endif
                end
            end
`ifdef WFUNC_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    rsum_nxt  = rsum_r ^ prdata;
                    if (cnt_r == CNT_LAST) begin
                        if ((rsum_r ^ prdata) != wsum_r) begin
                            err_verify_nxt = 1'b1;
                            done_nxt       = 1'b1;
                            state_nxt      = ST_IDLE;
                        end else begin
                            state_nxt = ST_ARM;
                        end
                    end else begin
                        cnt_nxt = cnt_r + CW'(1);
                    end
                end
            end
`endif
            ST_ARM: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else begin
                    shadow_nxt = shadow_r ^ CMD_ARM;
                    phase_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with state_r
    always_comb begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        pwrite_s  = 1'b0;
        paddr_s   = {APB_AW{1'b0}};
        pwdata_s  = 32'h0;
        tready_s  = 1'b0;
        busy_s    = 1'b0;
        case (state_nxt)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_RST: begin
                psel_s    = 1'b1;
                penable_s = phase_nxt;
                pwrite_s  = 1'b1;
                paddr_s   = CTRL_ADDR;
                pwdata_s  = shadow_nxt ^ CMD_RESET;
                busy_s    = 1'b1;
            end
            ST_LOAD_REQ: begin
                tready_s = 1'b1;
                busy_s   = 1'b1;
            end
            ST_LOAD_XFER: begin
                psel_s    = 1'b1;
                penable_s = phase_nxt;
                pwrite_s  = 1'b1;
                paddr_s   = APB_AW'({cnt_nxt, 2'b00});
                pwdata_s  = data_nxt;
                busy_s    = 1'b1;
            end
            ST_MODE: begin
                psel_s    = 1'b1;
                penable_s = phase_nxt;
                pwrite_s  = 1'b1;
                paddr_s   = MODE_ADDR;
                pwdata_s  = {31'h0, one_pack_nxt};
                busy_s    = 1'b1;
            end
            ST_VERIFY: begin
                psel_s    = 1'b1;
                penable_s = phase_nxt;
                pwrite_s  = 1'b0;
                paddr_s   = APB_AW'({cnt_nxt, 2'b00});
                busy_s    = 1'b1;
            end
            ST_ARM: begin
                psel_s    = 1'b1;
                penable_s = phase_nxt;
                pwrite_s  = 1'b1;
                paddr_s   = CTRL_ADDR;
                pwdata_s  = shadow_nxt ^ CMD_ARM;
                busy_s    = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            data_r     <= 32'h0;
            shadow_r   <= 32'h0;
            one_pack_r <= 1'b0;
            len_bad_r  <= 1'b0;
            err_len_r  <= 1'b0;
            done_r     <= 1'b0;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= {APB_AW{1'b0}};
            pwdata_r   <= 32'h0;
            tready_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt;
            data_r     <= data_nxt;
            shadow_r   <= shadow_nxt;
            one_pack_r <= one_pack_nxt;
            len_bad_r  <= len_bad_nxt;
            err_len_r  <= err_len_nxt;
            done_r     <= done_nxt;
            psel_r     <= psel_s;
            penable_r  <= penable_s;
            pwrite_r   <= pwrite_s;
            paddr_r    <= paddr_s;
            pwdata_r   <= pwdata_s;
            tready_r   <= tready_s;
            busy_r     <= busy_s;
        end
    end

`ifdef WFUNC_LOADER_VERIFY_EN
    // Readback accumulators and verify flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsum_r       <= 32'h0;
            rsum_r       <= 32'h0;
            err_verify_r <= 1'b0;
        end else begin
            wsum_r       <= wsum_nxt;
            rsum_r       <= rsum_nxt;
            err_verify_r <= err_verify_nxt;
        end
    end
    assign err_verify = err_verify_r;
`else
    assign err_verify = 1'b0;
`endif

    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign coef_tready = tready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_len     = err_len_r;

endmodule
